// File: rtl/dish_washer_plant_responder_pkg.sv
// ---------------------------------------------------------------------------
// dish_washer_pkg
// Shared types and default constants for the dish-washer plant responder.
//   - state_e / ST_* : FSM state encoding (3 bits)
//   - *_DEF          : default widths, level and timing constants
//   - eff_cycles()   : maps a phase length of 0 onto 1
// ---------------------------------------------------------------------------
package dish_washer_pkg;

    localparam int LVL_W_DEF        = 8;
    localparam int CNT_W_DEF        = 8;
    localparam int FILL_LEVEL_DEF   = 8;
    localparam int LEVEL_MAX_DEF    = 200;
    localparam int DRAIN_RATE_DEF   = 2;
    localparam int DET_CYCLES_DEF   = 2;
    localparam int WASH_CYCLES_DEF  = 6;
    localparam int STORE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILLING  = 3'd1,
        DOSING   = 3'd2,
        WASHING  = 3'd3,
        DRAINING = 3'd4,
        STORING  = 3'd5,
        FINISH   = 3'd6
    } state_e;

    // Plain-vector aliases so the FSM register stays a logic vector.
    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_FILLING  = FILLING;
    localparam logic [2:0] ST_DOSING   = DOSING;
    localparam logic [2:0] ST_WASHING  = WASHING;
    localparam logic [2:0] ST_DRAINING = DRAINING;
    localparam logic [2:0] ST_STORING  = STORING;
    localparam logic [2:0] ST_FINISH   = FINISH;

    // A phase length of zero would make the timer load -1; treat it as 1.
    function automatic int eff_cycles(input int p);
        return (p <= 0) ? 1 : p;
    endfunction

endpackage

// File: rtl/dish_washer_plant_responder_if.sv
// ---------------------------------------------------------------------------
// dish_washer_plant_responder_if
// Controller <-> plant signal bundle.
//   master : the washing controller (drives valves/lock/done, reads sensors)
//   slave  : the plant responder  (reads valves/lock/done, drives sensors)
// Sensor outputs are one-cycle pulses; Level is for observation only.
// ---------------------------------------------------------------------------
interface dish_washer_plant_responder_if
    import dish_washer_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF
);
    logic             Fill_valve_on;
    logic             Fill_valve_second_on;
    logic             Drained_valve_on;
    logic             Door_Lock;
    logic             Done;
    logic             Filled;
    logic             Detergent_Added;
    logic             Washing_Timeout;
    logic             Drained;
    logic             Store_Timeout;
    logic [LVL_W-1:0] Level;

    modport master (
        output Fill_valve_on, Fill_valve_second_on, Drained_valve_on, Door_Lock, Done,
        input  Filled, Detergent_Added, Washing_Timeout, Drained, Store_Timeout, Level
    );

    modport slave (
        input  Fill_valve_on, Fill_valve_second_on, Drained_valve_on, Door_Lock, Done,
        output Filled, Detergent_Added, Washing_Timeout, Drained, Store_Timeout, Level
    );
endinterface

// File: rtl/dish_washer_plant_responder_level_model.sv
// ---------------------------------------------------------------------------
// dish_washer_level_model
// Saturating water-level accumulator.
//   clk, rst_n     : clock, asynchronous active-low reset (level -> 0)
//   fill_a, fill_b : fill valves, each adds 1 per cycle
//   drain_on       : drain valve, subtracts DRAIN_RATE per cycle
//   fill_inhibit   : suppresses the fill contribution (drain still acts)
//   level          : registered level
//   next_level     : value level takes at the next edge
// ---------------------------------------------------------------------------
module dish_washer_level_model
    import dish_washer_pkg::*;
#(
    parameter int LVL_W      = LVL_W_DEF,
    parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int DRAIN_RATE = DRAIN_RATE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_a,
    input  logic             fill_b,
    input  logic             drain_on,
    input  logic             fill_inhibit,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] next_level
);
    // Two guard bits: one for the fill carry, one for the sign after draining.
    localparam int SW = LVL_W + 2;
    localparam logic signed [SW-1:0] MAX_S   = SW'(LEVEL_MAX);
    localparam logic signed [SW-1:0] DRAIN_S = SW'(DRAIN_RATE);

    logic [LVL_W-1:0]     level_reg;
    logic [LVL_W-1:0]     level_next;
    logic [1:0]           fill_rate;
    logic signed [SW-1:0] drain_s;
    logic signed [SW-1:0] sum;

    always_comb begin
        fill_rate = fill_inhibit ? 2'd0 : ({1'b0, fill_a} + {1'b0, fill_b});
        drain_s   = drain_on ? DRAIN_S : SW'(0);
        sum       = $signed({2'b00, level_reg}) + $signed({{LVL_W{1'b0}}, fill_rate}) - drain_s;
        if (sum[SW-1])
            level_next = '0;
        else if (sum > MAX_S)
            level_next = LVL_W'(LEVEL_MAX);
        else
            level_next = sum[LVL_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_reg <= '0;
        else
            level_reg <= level_next;
    end

    assign level      = level_reg;
    assign next_level = level_next;
endmodule

// File: rtl/dish_washer_plant_responder.sv
// ---------------------------------------------------------------------------
// dish_washer_plant_responder
// Behavioural plant for the dish-washing controller: turns valve/lock/done
// commands into the Filled / Detergent_Added / Washing_Timeout / Drained /
// Store_Timeout pulses the controller waits for.
//   Clock   : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of dish_washer_plant_responder_if
// Build option DOOR_INTERLOCK_EN: with Door_Lock low the WASHING/STORING
// timers freeze and the fill valves have no effect while FILLING. Without
// it Door_Lock is ignored.
// ---------------------------------------------------------------------------
module dish_washer_plant_responder
    import dish_washer_pkg::*;
#(
    parameter int LVL_W        = LVL_W_DEF,
    parameter int FILL_LEVEL   = FILL_LEVEL_DEF,
    parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
    parameter int DRAIN_RATE   = DRAIN_RATE_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DET_CYCLES   = DET_CYCLES_DEF,
    parameter int WASH_CYCLES  = WASH_CYCLES_DEF,
    parameter int STORE_CYCLES = STORE_CYCLES_DEF
) (
    input logic                           Clock,
    input logic                           Reset_n,
    dish_washer_plant_responder_if.slave  bus
);
    localparam logic [CNT_W-1:0] DET_LOAD   = CNT_W'(eff_cycles(DET_CYCLES) - 1);
    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(eff_cycles(WASH_CYCLES) - 1);
    localparam logic [CNT_W-1:0] STORE_LOAD = CNT_W'(eff_cycles(STORE_CYCLES) - 1);
    localparam logic [LVL_W-1:0] FILL_LVL_V = LVL_W'(FILL_LEVEL);

    // Pulse vector bit order.
    localparam int P_FILLED = 0;
    localparam int P_DET    = 1;
    localparam int P_WASH   = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_STORE  = 4;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic [4:0]       pulse_reg, pulse_next;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] next_level;
    logic             fill_any;
    logic             door_hold;
    logic             fill_inhibit;

`ifdef DOOR_INTERLOCK_EN
    assign door_hold = ~bus.Door_Lock;
`else
    logic door_lock_unused;
    assign door_lock_unused = bus.Door_Lock;
    assign door_hold        = 1'b0;
`endif

    assign fill_any     = bus.Fill_valve_on | bus.Fill_valve_second_on;
    assign fill_inhibit = door_hold && (state_reg == ST_FILLING);

    dish_washer_level_model #(
        .LVL_W      (LVL_W),
        .LEVEL_MAX  (LEVEL_MAX),
        .DRAIN_RATE (DRAIN_RATE)
    ) u_level (
        .clk          (Clock),
        .rst_n        (Reset_n),
        .fill_a       (bus.Fill_valve_on),
        .fill_b       (bus.Fill_valve_second_on),
        .drain_on     (bus.Drained_valve_on),
        .fill_inhibit (fill_inhibit),
        .level        (level),
        .next_level   (next_level)
    );

    // Conditions are judged on next_level so the pulse lines up with the
    // edge at which the level actually reaches the threshold.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pulse_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (fill_any)
                    state_next = ST_FILLING;
            end
            ST_FILLING: begin
                if (next_level >= FILL_LVL_V) begin
                    pulse_next[P_FILLED] = 1'b1;
                    timer_next           = DET_LOAD;
                    state_next           = ST_DOSING;
                end
            end
            ST_DOSING: begin
                if (timer_reg == '0) begin
                    pulse_next[P_DET] = 1'b1;
                    timer_next        = WASH_LOAD;
                    state_next        = ST_WASHING;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            ST_WASHING: begin
                if (!door_hold) begin
                    if (timer_reg == '0) begin
                        pulse_next[P_WASH] = 1'b1;
                        state_next         = ST_DRAINING;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
            end
            ST_DRAINING: begin
                if (bus.Drained_valve_on && (next_level == '0)) begin
                    pulse_next[P_DRAIN] = 1'b1;
                    timer_next          = STORE_LOAD;
                    state_next          = ST_STORING;
                end
            end
            ST_STORING: begin
                if (!door_hold) begin
                    if (timer_reg == '0) begin
                        pulse_next[P_STORE] = 1'b1;
                        state_next          = ST_FINISH;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                if (bus.Done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            pulse_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            pulse_reg <= pulse_next;
        end
    end

    assign bus.Filled          = pulse_reg[P_FILLED];
    assign bus.Detergent_Added = pulse_reg[P_DET];
    assign bus.Washing_Timeout = pulse_reg[P_WASH];
    assign bus.Drained         = pulse_reg[P_DRAIN];
    assign bus.Store_Timeout   = pulse_reg[P_STORE];
    assign bus.Level           = level;
endmodule

// File: doc/dish_washer_plant_responder.md
Name: dish_washer_plant_responder

Overview:
- Behavioural plant/sensor emulator for the dish-washing controller, on the opposite end of its interface.
- Consumes the controller's actuator outputs: fill valves, drain valve, door lock and done.
- Produces the sensor and timer events the controller consumes: Filled, Detergent_Added, Washing_Timeout, Drained, Store_Timeout.
- Closes the loop for self-running system benches; also used as the synthesizable plant in FPGA demo builds.

Parameters:
- LVL_W, 8, water-level counter width
- FILL_LEVEL, 8, level at which Filled fires
- LEVEL_MAX, 200, level saturation ceiling
- DRAIN_RATE, 2, level decrement per cycle while the drain valve is on
- CNT_W, 8, phase-timer width
- DET_CYCLES, 2, cycles from Filled to Detergent_Added
- WASH_CYCLES, 6, cycles from Detergent_Added to Washing_Timeout
- STORE_CYCLES, 4, cycles from Drained to Store_Timeout

Ports:
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Fill_valve_on  in  1  primary fill valve command
- Fill_valve_second_on  in  1  secondary fill valve command
- Drained_valve_on  in  1  drain valve command
- Door_Lock  in  1  door locked
- Done  in  1  controller cycle complete
- Filled  out  1  one-cycle pulse: target level reached
- Detergent_Added  out  1  one-cycle pulse: dosing complete
- Washing_Timeout  out  1  one-cycle pulse: wash time elapsed
- Drained  out  1  one-cycle pulse: tank empty
- Store_Timeout  out  1  one-cycle pulse: store/dry time elapsed
- Level  out  LVL_W  current water level, for observation

Behaviour:
- Reset: one clock; Reset_n is asynchronous, active-low. Asserting it forces state=IDLE, Level=0, timer=0 and all five pulse outputs to 0, effective immediately, including mid-operation. Release is sampled synchronously.
- Level model, updated every cycle in every state:
  - fill_rate = Fill_valve_on + Fill_valve_second_on (0..2).
  - drain term = DRAIN_RATE when Drained_valve_on, else 0.
  - Next Level = Level + fill_rate − drain term, computed at LVL_W+2 signed width.
  - Result clamps to 0 and saturates at LEVEL_MAX.
  - Simultaneous fill and drain gives the net result.
- All pulse outputs are registered. A pulse is high for exactly the one cycle after the edge at which its condition is detected. At most one pulse is high in any cycle.
- FSM:
  - IDLE: when fill_rate != 0 → FILLING.
  - FILLING: when next Level >= FILL_LEVEL → pulse Filled, timer=DET_CYCLES−1, → DOSING.
  - DOSING: timer decrements each cycle. At timer==0 → pulse Detergent_Added, timer=WASH_CYCLES−1, → WASHING.
  - WASHING: timer decrements. At 0 → pulse Washing_Timeout, → DRAINING.
  - DRAINING: when Drained_valve_on=1 and next Level==0 → pulse Drained, timer=STORE_CYCLES−1, → STORING. If Level is already 0 on entry, Drained fires the first cycle Drained_valve_on=1.
  - STORING: timer decrements. At 0 → pulse Store_Timeout, → FINISH.
  - FINISH: when Done=1 → IDLE. Done in any other state is ignored.
- Timers never wrap. A parameter value of 0 is treated as 1.
- A fill valve opening outside IDLE/FILLING changes Level only; it triggers no state change.

Optional Feature:
- Macro: DOOR_INTERLOCK_EN.
- Defined:
  - In WASHING and STORING the timer holds while Door_Lock=0 and resumes when Door_Lock returns to 1.
  - In FILLING, Level does not increase while Door_Lock=0.
- Undefined: Door_Lock is ignored entirely.

Decomposition:
- Package dish_washer_pkg:
  - state enum: IDLE, FILLING, DOSING, WASHING, DRAINING, STORING, FINISH.
  - default timing constants.
  - LVL_W/CNT_W defaults.
- One natural sub-module, dish_washer_level_model: saturating level accumulator taking the valve inputs and producing Level and next_level. The FSM and timers stay in the top.

Test Plan:
- Reset: Reset_n=0 asserted mid-WASHING with Level=8 → all outputs 0 and Level 0 within the same cycle; Reset_n=1 → IDLE.
- Single valve: Fill_valve_on=1 from IDLE → Filled pulse after 8 edges, Level=8. Then Detergent_Added 2 cycles later and Washing_Timeout 6 cycles after that.
- Both valves: fill from 0 → Filled after 4 edges. Level keeps rising while the valves stay open and saturates at 200.
- Drain: Level=8, DRAINING, Drained_valve_on=1 → Drained after 4 edges, Level=0. Store_Timeout 4 cycles later. Done=1 → IDLE.
- Simultaneous: Fill_valve_on=1 and Drained_valve_on=1 with Level=5 → Level decreases by 1 per cycle and clamps at 0, with no underflow wrap.
- DOOR_INTERLOCK_EN: Door_Lock=0 for 3 cycles mid-WASHING → Washing_Timeout is delayed by exactly 3 cycles. With the macro undefined, there is no delay.
